decision_sequencer: RTL and testbench
=====================================

Name: decision_sequencer

Overview:
- Controller for the NPU's 10-class argmax comparator. It sits between the output-layer adder tree and the comparator.
- Collects one image's class scores from upstream using a valid/ready handshake and buffers them locally.
- Replays the scores to the comparator as one contiguous burst, then captures the decision and returns it downstream.
- Pulses the comparator's reset between images, because the comparator cannot re-arm itself.

Parameters:
NUM_CLASS, 10, scores per image; legal range 2..15; the comparator instance requires 10
DW, 12, signed score width
LAT_TIMEOUT, 16, cycles allowed in WAIT for cmp_valid_out before an error is declared
RST_HOLD, 2, cycles cmp_rst_n is held low in CLEAR; minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  reset
score_valid  in  1  upstream score valid
score_data  in  DW  upstream signed score; class index = arrival order
score_ready  out  1  controller accepts a score (combinational, high only in COLLECT)
cmp_rst_n  out  1  registered synchronous active-low reset to the comparator
cmp_valid_in  out  1  registered score strobe to the comparator
cmp_data_in  out  DW  registered score to the comparator
cmp_decision  in  4  comparator argmax result
cmp_valid_out  in  1  comparator single-cycle result strobe
dec_valid  out  1  decision available downstream
dec_ready  in  1  downstream accepts the decision
dec_class  out  4  winning class index; 4'hF on timeout
dec_error  out  1  set with dec_valid when the comparator timed out
img_count  out  16  completed (handshaken) decisions, wraps at 2^16
busy  out  1  high in every state except COLLECT with zero scores accepted

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
- Values while rst_n is low: cmp_rst_n=0, cmp_valid_in=0, cmp_data_in=0, dec_valid=0, dec_class=0, dec_error=0, img_count=0, score index=0, state=CLEAR with hold counter=0.
- State machine: CLEAR -> COLLECT -> ISSUE -> WAIT -> OUTPUT -> CLEAR.
- CLEAR:
  - cmp_rst_n stays low for exactly RST_HOLD cycles, counted from the first cycle after rst_n rises or from entry into CLEAR.
  - cmp_rst_n goes high on the cycle the state becomes COLLECT.
  - score_ready=0.
- COLLECT:
  - score_ready=1.
  - Each cycle with score_valid&score_ready writes score_data into buffer[idx] and increments idx.
  - The accept that brings idx to NUM_CLASS moves the state to ISSUE on the next cycle; idx clears.
  - Cycles with score_valid low are gaps; they are allowed and do not count as accepts.
- ISSUE:
  - cmp_valid_in=1 for exactly NUM_CLASS consecutive cycles.
  - cmp_data_in = buffer[0], buffer[1], ... in order.
  - After the last beat, cmp_valid_in=0 and cmp_data_in=0, and the state is WAIT.
- WAIT:
  - A wait counter starts at 0 on the first WAIT cycle and increments every cycle.
  - cmp_valid_out=1 seen: latch cmp_decision into dec_class, dec_error=0, go to OUTPUT.
  - Counter reaches LAT_TIMEOUT-1 with no strobe: dec_class=4'hF, dec_error=1, go to OUTPUT.
  - If the strobe and the timeout occur in the same cycle, the strobe wins.
  - The comparator normally strobes 7 cycles after the last beat.
- OUTPUT:
  - dec_valid=1 from the cycle after the WAIT exit.
  - dec_class and dec_error stay stable while dec_valid=1 and dec_ready=0.
  - Transfer occurs on dec_valid&dec_ready. On the next cycle: dec_valid=0, img_count+1 (0xFFFF wraps to 0), state=CLEAR.
  - dec_class and dec_error hold their values until overwritten in the next WAIT.
- cmp_valid_out outside WAIT is ignored.
- Ties are resolved by the comparator (lowest index wins) and passed through unchanged.
- rst_n low mid-image: the partial image is discarded, no decision is emitted, and the comparator is reset through cmp_rst_n.
- Downstream stall: a stalled dec_ready holds the machine in OUTPUT; no new scores are accepted, so there is no overflow.
- Scores are carried as two's complement at DW bits throughout, with no truncation or extension.

Test Plan:
- Release reset, then observe: cmp_rst_n low for 2 cycles after rst_n rises, then high. At that point score_ready=1, busy=0, and all other outputs are 0.
- Scores {5,-3,100,7,0,-50,20,99,1,2} back-to-back, dec_ready=1 -> cmp_valid_in high for 10 contiguous cycles in the same order; dec_class=2, dec_error=0, img_count=1.
- Same scores with score_valid deasserted every other cycle -> the ISSUE burst is still 10 contiguous beats and dec_class=2.
- Scores {-8,-8,-1,-1,...,-1} with ties at -1 -> dec_class=2.
- Comparator model that never strobes -> dec_valid rises LAT_TIMEOUT+1 cycles after the last beat with dec_class=4'hF and dec_error=1. The next image then decodes correctly after CLEAR.
- Hold dec_ready=0 for 20 cycles -> dec_valid and dec_class remain stable and score_ready=0. On release, img_count increments once.
- Assert rst_n low after 6 scores are accepted -> no decision is produced. Then a full image with max at index 9 -> dec_class=9, img_count=1.

Source files
------------

// File: rtl/decision_sequencer.sv
// rtl/decision_sequencer.sv - buffers one image's class scores, replays them to the argmax comparator, returns the decision
module decision_sequencer #(
    parameter int NUM_CLASS   = 10,
    parameter int DW          = 12,
    parameter int LAT_TIMEOUT = 16,
    parameter int RST_HOLD    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          score_valid,
    input  logic [DW-1:0] score_data,
    output logic          score_ready,
    output logic          cmp_rst_n,
    output logic          cmp_valid_in,
    output logic [DW-1:0] cmp_data_in,
    input  logic [3:0]    cmp_decision,
    input  logic          cmp_valid_out,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [3:0]    dec_class,
    output logic          dec_error,
    output logic [15:0]   img_count,
    output logic          busy
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int WW = $clog2(LAT_TIMEOUT + 1);

    localparam logic [2:0] S_CLEAR   = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    beat_q, beat_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          cmp_rst_n_q, cmp_rst_n_d;
    logic          cmp_valid_in_q, cmp_valid_in_d;
    logic [DW-1:0] cmp_data_in_q, cmp_data_in_d;
    logic          dec_valid_q, dec_valid_d;
    logic [3:0]    dec_class_q, dec_class_d;
    logic          dec_error_q, dec_error_d;
    logic [15:0]   img_count_q, img_count_d;
    logic [DW-1:0] buf_q [NUM_CLASS];
    logic          accept;

    assign score_ready  = (state_q == S_COLLECT);
    assign accept       = score_ready & score_valid;
    assign busy         = !((state_q == S_COLLECT) && (idx_q == 4'd0));
    assign cmp_rst_n    = cmp_rst_n_q;
    assign cmp_valid_in = cmp_valid_in_q;
    assign cmp_data_in  = cmp_data_in_q;
    assign dec_valid    = dec_valid_q;
    assign dec_class    = dec_class_q;
    assign dec_error    = dec_error_q;
    assign img_count    = img_count_q;

    always_ff @(posedge clk) begin
        if (accept) buf_q[idx_q] <= score_data;
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        idx_d          = idx_q;
        beat_d         = beat_q;
        wait_d         = wait_q;
        cmp_rst_n_d    = cmp_rst_n_q;
        cmp_valid_in_d = 1'b0;
        cmp_data_in_d  = '0;
        dec_valid_d    = dec_valid_q;
        dec_class_d    = dec_class_q;
        dec_error_d    = dec_error_q;
        img_count_d    = img_count_q;
        case (state_q)
            S_CLEAR: begin
                if (hold_q == HW'(RST_HOLD - 1)) begin
                    state_d     = S_COLLECT;
                    cmp_rst_n_d = 1'b1;
                    hold_d      = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (score_valid) begin
                    if (idx_q == 4'(NUM_CLASS - 1)) begin
                        // First beat launches on the same edge as the last accept so the burst is gap-free.
                        state_d        = S_ISSUE;
                        idx_d          = 4'd0;
                        beat_d         = 4'd1;
                        cmp_valid_in_d = 1'b1;
                        cmp_data_in_d  = buf_q[0];
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (beat_q == 4'(NUM_CLASS)) begin
                    state_d = S_WAIT;
                    beat_d  = 4'd0;
                    wait_d  = '0;
                end else begin
                    cmp_valid_in_d = 1'b1;
                    cmp_data_in_d  = buf_q[beat_q];
                    beat_d         = beat_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cmp_valid_out) begin
                    state_d     = S_OUTPUT;
                    dec_valid_d = 1'b1;
                    dec_class_d = cmp_decision;
                    dec_error_d = 1'b0;
                end else if (wait_q == WW'(LAT_TIMEOUT - 1)) begin
                    state_d     = S_OUTPUT;
                    dec_valid_d = 1'b1;
                    dec_class_d = 4'hF;
                    dec_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (dec_ready) begin
                    state_d     = S_CLEAR;
                    dec_valid_d = 1'b0;
                    img_count_d = img_count_q + 16'd1;
                    hold_d      = '0;
                    cmp_rst_n_d = 1'b0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_CLEAR;
            hold_q         <= '0;
            idx_q          <= 4'd0;
            beat_q         <= 4'd0;
            wait_q         <= '0;
            cmp_rst_n_q    <= 1'b0;
            cmp_valid_in_q <= 1'b0;
            cmp_data_in_q  <= '0;
            dec_valid_q    <= 1'b0;
            dec_class_q    <= 4'd0;
            dec_error_q    <= 1'b0;
            img_count_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            idx_q          <= idx_d;
            beat_q         <= beat_d;
            wait_q         <= wait_d;
            cmp_rst_n_q    <= cmp_rst_n_d;
            cmp_valid_in_q <= cmp_valid_in_d;
            cmp_data_in_q  <= cmp_data_in_d;
            dec_valid_q    <= dec_valid_d;
            dec_class_q    <= dec_class_d;
            dec_error_q    <= dec_error_d;
            img_count_q    <= img_count_d;
        end
    end
endmodule

// File: tb/tb_decision_sequencer.sv
// tb/tb_decision_sequencer.sv - self-checking bench for decision_sequencer with a comparator model
module tb_decision_sequencer;
    localparam int NC = 10;
    localparam int DW = 12;
    localparam int LT = 16;
    localparam int RH = 2;

    typedef logic [NC-1:0][DW-1:0] img_t;
    typedef struct packed {
        img_t       s;
        logic       gap;
        logic [3:0] exp_class;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          score_valid, score_ready;
    logic [DW-1:0] score_data;
    logic          cmp_rst_n, cmp_valid_in, cmp_valid_out;
    logic [DW-1:0] cmp_data_in;
    logic [3:0]    cmp_decision;
    logic          dec_valid, dec_ready, dec_error, busy;
    logic [3:0]    dec_class;
    logic [15:0]   img_count;

    always #5 clk = ~clk;

    decision_sequencer #(.NUM_CLASS(NC), .DW(DW), .LAT_TIMEOUT(LT), .RST_HOLD(RH)) dut (
        .clk(clk), .rst_n(rst_n),
        .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
        .cmp_rst_n(cmp_rst_n), .cmp_valid_in(cmp_valid_in), .cmp_data_in(cmp_data_in),
        .cmp_decision(cmp_decision), .cmp_valid_out(cmp_valid_out),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_class(dec_class),
        .dec_error(dec_error), .img_count(img_count), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_count = 0;
    int dec_seen = 0;
    bit no_strobe = 0;
    logic [DW-1:0] beats[$];
    int beat_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Comparator stand-in: argmax over NC beats, strobes 7 cycles after the last beat.
    int cm_cnt = 0, cm_cd = 0;
    logic signed [DW-1:0] cm_best;
    logic [3:0] cm_idx;
    always @(negedge clk) begin
        cmp_valid_out = 1'b0;
        if (cmp_rst_n !== 1'b1) begin
            cm_cnt = 0;
            cm_cd  = 0;
        end else begin
            if (cm_cd > 0) begin
                cm_cd--;
                if (cm_cd == 0 && !no_strobe) begin
                    cmp_valid_out = 1'b1;
                    cmp_decision  = cm_idx;
                end
            end
            if (cmp_valid_in === 1'b1) begin
                if (cm_cnt == 0 || $signed(cmp_data_in) > cm_best) begin
                    cm_best = $signed(cmp_data_in);
                    cm_idx  = cm_cnt[3:0];
                end
                cm_cnt++;
                if (cm_cnt == NC) begin
                    cm_cd  = 7;
                    cm_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_valid_in === 1'b1) begin
            beats.push_back(cmp_data_in);
            beat_cyc.push_back(cyc);
        end
        if (dec_valid === 1'b1) dec_seen++;
    end

    function automatic int ref_argmax(input img_t im);
        int b = 0;
        for (int i = 1; i < NC; i++)
            if ($signed(im[i]) > $signed(im[b])) b = i;
        return b;
    endfunction

    task automatic send_scores(input img_t im, input int n, input bit gap);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                score_valid = 1'b0;
                @(negedge clk);
            end
            score_valid = 1'b1;
            score_data  = im[i];
            w = 0;
            while (score_ready !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                chk("score_ready_wait", score_ready, 1);
                break;
            end
            @(negedge clk);
        end
        score_valid = 1'b0;
    endtask

    task automatic run_image(input img_t im, input bit gap, input bit nostrobe, input int exp_cls,
                             input bit exp_err, input int stall, input int exp_lat);
        int w, bad, cnt;
        bit stable;
        logic [3:0] c0;
        beats.delete();
        beat_cyc.delete();
        no_strobe = nostrobe;
        dec_ready = (stall == 0);
        send_scores(im, NC, gap);
        w = 0;
        while (dec_valid !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("dec_valid_seen", dec_valid, 1);
        chk("beat_count", beats.size(), NC);
        if (beats.size() == NC) begin
            chk("burst_contig", beat_cyc[NC-1] - beat_cyc[0], NC - 1);
            bad = 0;
            for (int i = 0; i < NC; i++)
                if (beats[i] !== im[i]) bad++;
            chk("beat_order", bad, 0);
            chk("latency", cyc - beat_cyc[NC-1], exp_lat);
        end
        chk("dec_class", dec_class, exp_cls);
        chk("dec_error", dec_error, exp_err);
        if (stall > 0) begin
            stable = 1;
            c0 = dec_class;
            for (int s = 0; s < stall; s++) begin
                if (dec_valid !== 1'b1 || dec_class !== c0 || score_ready !== 1'b0) stable = 0;
                @(negedge clk);
            end
            chk("stall_stable", stable, 1);
            chk("stall_count", img_count, exp_count);
            dec_ready = 1'b1;
        end
        @(negedge clk);
        exp_count++;
        chk("dec_valid_drop", dec_valid, 0);
        chk("img_count", img_count, exp_count);
        cnt = 0;
        w = 0;
        while (score_ready !== 1'b1 && w < 20) begin
            if (cmp_rst_n !== 1'b1) cnt++;
            @(negedge clk);
            w++;
        end
        chk("clear_hold", cnt, RH);
        if (stall > 0) chk("img_count_once", img_count, exp_count);
        no_strobe = 0;
    endtask

    vec_t vecs[5];
    int tmp[NC];
    img_t rim;
    int seen0;

    task automatic load_vec(input int k, input bit gap, input int exp);
        for (int j = 0; j < NC; j++) vecs[k].s[j] = tmp[j][DW-1:0];
        vecs[k].gap = gap;
        vecs[k].exp_class = exp[3:0];
    endtask

    initial begin
        score_valid = 0; score_data = '0; dec_ready = 1;
        cmp_valid_out = 0; cmp_decision = '0;
        tmp = '{5, -3, 100, 7, 0, -50, 20, 99, 1, 2};           load_vec(0, 0, 2);
        tmp = '{5, -3, 100, 7, 0, -50, 20, 99, 1, 2};           load_vec(1, 1, 2);
        tmp = '{-8, -8, -1, -1, -1, -1, -1, -1, -1, -1};        load_vec(2, 0, 2);
        tmp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};                  load_vec(3, 1, 9);
        tmp = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048}; load_vec(4, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_cmp_rst_n", cmp_rst_n, 0);
        chk("rst_cmp_valid_in", cmp_valid_in, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_img_count", img_count, 0);
        chk("rst_score_ready", score_ready, 0);
        rst_n = 1;
        @(negedge clk);
        chk("hold_low", cmp_rst_n, 0);
        @(negedge clk);
        chk("hold_release", cmp_rst_n, 1);
        chk("idle_score_ready", score_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_outputs", {cmp_valid_in, cmp_data_in, dec_valid, dec_class, dec_error, img_count}, 0);

        for (int i = 0; i < 5; i++)
            run_image(vecs[i].s, vecs[i].gap, 0, vecs[i].exp_class, 0, 0, 8);

        run_image(vecs[0].s, 0, 1, 15, 1, 0, LT + 1);
        run_image(vecs[0].s, 0, 0, 2, 0, 0, 8);
        run_image(vecs[1].s, 0, 0, 2, 0, 20, 8);

        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < NC; j++)
                rim[j] = (r % 2 == 1) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
            run_image(rim, 1'($urandom_range(0, 1)), 0, ref_argmax(rim), 0, 0, 8);
        end

        send_scores(vecs[3].s, 6, 0);
        chk("partial_busy", busy, 1);
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("midrst_cmp_rst_n", cmp_rst_n, 0);
        chk("midrst_img_count", img_count, 0);
        rst_n = 1;
        exp_count = 0;
        seen0 = dec_seen;
        repeat (30) @(negedge clk);
        chk("midrst_no_decision", dec_seen - seen0, 0);
        run_image(vecs[3].s, 0, 0, 9, 0, 0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
